vram_arbiter: RTL and testbench

Single-port video-RAM arbiter that shares one synchronous VRAM between the tile renderer's fetch port and a host/CPU access port. It sits between the tile-render top and the VRAM macro inside the 8bitworkshop wrapper and runs on the same divided pixel clock as the renderer. The video port has strict priority, with a bounded-starvation escape for the host. Real-time video misses are flagged rather than silently lost.

---
 rtl/vram_arb_pkg.sv | 35 +++
 rtl/vram_arb_starve_ctr.sv | 30 +++
 rtl/vram_arbiter.sv | 115 +++++++++++
 tb/tb_vram_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM arbiter: grant tags, host FSM states and the
// priority decision used by the top level.
package vram_arb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_CPU  = 2'd2
    } grant_t;

    typedef enum logic [1:0] {
        C_IDLE   = 2'd0,
        C_ISSUED = 2'd1,
        C_DATA   = 2'd2
    } host_state_t;

    localparam int STARVE_W = 8;

    // A starved host overrides video; otherwise video always wins.
    function automatic grant_t pick_grant(input logic starve_hit,
                                          input logic vid_req,
                                          input logic cpu_elig);
        grant_t g;
        if (starve_hit && cpu_elig)
            g = GNT_CPU;
        else if (vid_req)
            g = GNT_VID;
        else if (cpu_elig)
            g = GNT_CPU;
        else
            g = GNT_NONE;
        return g;
    endfunction

endpackage

// File: rtl/vram_arb_starve_ctr.sv
// Saturating count of consecutive cycles a pending host request lost to video;
// starve_hit flags that the host must win the next arbitration.
module vram_arb_starve_ctr
    import vram_arb_pkg::*;
#(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic starve_hit
);

    localparam logic [STARVE_W-1:0] LIMIT_V = STARVE_W'(LIMIT);

    logic [STARVE_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_reg <= '0;
        else if (clr)
            cnt_reg <= '0;
        else if (inc && (cnt_reg != LIMIT_V))
            cnt_reg <= cnt_reg + 1'b1;
    end

    assign starve_hit = (cnt_reg == LIMIT_V);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: renderer fetch port with strict priority, host port
// with bounded starvation. Both ports see a fixed 2-cycle read latency.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    output logic              vid_miss,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    host_state_t host_state_reg;
    grant_t      gnt_s1_reg;
    grant_t      gnt_s2_reg;
    logic        cpu_wr_s2_reg;
    grant_t      grant_next;
    logic        cpu_elig;
    logic        starve_hit;
    logic        starve_inc;
    logic        starve_clr;

    assign cpu_elig   = cpu_req && (host_state_reg == C_IDLE);
    assign grant_next = pick_grant(starve_hit, vid_req, cpu_elig);
    assign starve_inc = cpu_elig && (grant_next == GNT_VID);
    assign starve_clr = (grant_next == GNT_CPU) || !cpu_req;

    vram_arb_starve_ctr #(
        .LIMIT(STARVE_MAX)
    ) u_starve (
        .clk       (clk),
        .reset     (reset),
        .inc       (starve_inc),
        .clr       (starve_clr),
        .starve_hit(starve_hit)
    );

    // Host FSM only tracks the in-flight host access so it cannot be regranted early.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            host_state_reg <= C_IDLE;
        end else begin
            case (host_state_reg)
                C_IDLE:   if (grant_next == GNT_CPU) host_state_reg <= C_ISSUED;
                C_ISSUED: host_state_reg <= C_DATA;
                C_DATA:   host_state_reg <= C_IDLE;
                default:  host_state_reg <= C_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_s1_reg    <= GNT_NONE;
            gnt_s2_reg    <= GNT_NONE;
            cpu_wr_s2_reg <= 1'b0;
            ram_addr      <= '0;
            ram_we        <= 1'b0;
            ram_wdata     <= '0;
            vid_data      <= '0;
            vid_valid     <= 1'b0;
            vid_miss      <= 1'b0;
            cpu_rdata     <= '0;
            cpu_ack       <= 1'b0;
        end else begin
            gnt_s1_reg    <= grant_next;
            gnt_s2_reg    <= gnt_s1_reg;
            cpu_wr_s2_reg <= ram_we;
            ram_we        <= 1'b0;

            case (grant_next)
                GNT_VID: begin
                    ram_addr <= vid_addr;
                end
                GNT_CPU: begin
                    ram_addr <= cpu_addr;
                    ram_we   <= cpu_we;
                    if (cpu_we)
                        ram_wdata <= cpu_wdata;
                end
                default: ;
            endcase

            // A video request only coexists with a CPU grant when the host was forced in.
            if (vid_req && (grant_next == GNT_CPU))
                vid_miss <= 1'b1;

            // The grant tag two stages back says who owns the word now on ram_rdata.
            vid_valid <= (gnt_s2_reg == GNT_VID);
            if (gnt_s2_reg == GNT_VID)
                vid_data <= ram_rdata;

            cpu_ack <= (gnt_s2_reg == GNT_CPU);
            if ((gnt_s2_reg == GNT_CPU) && !cpu_wr_s2_reg)
                cpu_rdata <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios followed by random
// traffic, all compared against a transaction-level timeline model.
module tb_vram_arbiter;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int SM = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          vid_valid;
    logic          vid_miss;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    always #5 clk = ~clk;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
        .vid_valid(vid_valid), .vid_miss(vid_miss),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Synchronous VRAM macro
    logic [DW-1:0] mem [1024];
    always @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Reference model: each grant schedules a completion two steps later.
    typedef struct {
        int            due;
        bit            is_vid;
        bit            is_wr;
        logic [DW-1:0] data;
    } ev_t;

    ev_t           evq[$];
    logic [DW-1:0] mem_model [1024];
    int            busy;
    int            waitc;
    bit            miss;
    logic [AW-1:0] exp_ram_addr;
    bit            exp_ram_we;
    int            cyc;
    int            checks;
    int            pass_cnt;
    int            vv_count;
    int            ack_count;
    int            we_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        evq.delete();
        busy         = 0;
        waitc        = 0;
        miss         = 0;
        exp_ram_addr = '0;
        exp_ram_we   = 0;
    endtask

    task automatic step();
        bit            elig;
        int            g;
        bit            exp_vv;
        bit            exp_ack;
        bit            exp_wr;
        logic [DW-1:0] exp_vd;
        logic [DW-1:0] exp_rd;
        ev_t           e;

        elig = cpu_req && (busy == 0);
        if (elig && waitc == SM)  g = 2;
        else if (vid_req)         g = 1;
        else if (elig)            g = 2;
        else                      g = 0;

        if (g == 2 && vid_req) miss = 1;
        if (g == 2 || !cpu_req)                    waitc = 0;
        else if (elig && g == 1 && waitc < SM)     waitc++;
        if (g == 2)        busy = 2;
        else if (busy > 0) busy--;

        exp_ram_we = (g == 2) && cpu_we;
        if (g == 1) begin
            exp_ram_addr = vid_addr;
            evq.push_back('{cyc + 2, 1'b1, 1'b0, mem_model[vid_addr]});
        end else if (g == 2) begin
            exp_ram_addr = cpu_addr;
            if (cpu_we) mem_model[cpu_addr] = cpu_wdata;
            evq.push_back('{cyc + 2, 1'b0, cpu_we, cpu_we ? '0 : mem_model[cpu_addr]});
        end

        @(posedge clk);
        #1;

        exp_vv = 0; exp_ack = 0; exp_wr = 0; exp_vd = '0; exp_rd = '0;
        while (evq.size() > 0 && evq[0].due == cyc) begin
            e = evq.pop_front();
            if (e.is_vid) begin
                exp_vv = 1; exp_vd = e.data;
            end else begin
                exp_ack = 1; exp_wr = e.is_wr; exp_rd = e.data;
            end
        end

        chk("vid_valid", vid_valid, exp_vv);
        if (exp_vv) chk("vid_data", vid_data, exp_vd);
        chk("cpu_ack", cpu_ack, exp_ack);
        if (exp_ack && !exp_wr) chk("cpu_rdata", cpu_rdata, exp_rd);
        chk("vid_miss", vid_miss, miss);
        chk("ram_we", ram_we, exp_ram_we);
        chk("ram_addr", ram_addr, exp_ram_addr);

        if (vid_valid) vv_count++;
        if (cpu_ack)   ack_count++;
        if (ram_we)    we_count++;
        cyc++;
    endtask

    // Holds a host request until its ack; returns steps from first edge to ack.
    task automatic wait_ack(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!cpu_ack && n < 12);
        if (!cpu_ack) chk("ack_timeout", 32'd0, 32'd1);
        cpu_req = 0;
    endtask

    int n;
    int vv0;
    int we0;

    initial begin
        checks = 0; pass_cnt = 0; cyc = 0;
        vv_count = 0; ack_count = 0; we_count = 0;
        for (int i = 0; i < 1024; i++) begin
            mem[i]       = 16'(i + 16'h100);
            mem_model[i] = 16'(i + 16'h100);
        end
        reset = 1; vid_req = 0; vid_addr = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vid_valid", vid_valid, 1'b0);
        chk("rst_vid_data",  vid_data,  16'h0);
        chk("rst_cpu_ack",   cpu_ack,   1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 16'h0);
        chk("rst_ram_addr",  ram_addr,  10'h0);
        chk("rst_ram_we",    ram_we,    1'b0);
        chk("rst_ram_wdata", ram_wdata, 16'h0);
        chk("rst_vid_miss",  vid_miss,  1'b0);
        reset = 0;

        // Back-to-back video stream
        vv0 = vv_count;
        for (int a = 0; a < 8; a++) begin
            vid_req = 1; vid_addr = AW'(a);
            step();
        end
        vid_req = 0;
        repeat (3) step();
        chk("stream_count", vv_count - vv0, 8);

        // Host write then read-back
        we0 = we_count;
        cpu_req = 1; cpu_we = 1; cpu_addr = 10'h3FF; cpu_wdata = 16'hBEEF;
        wait_ack(n);
        chk("wr_latency", n, 3);
        chk("wr_we_cycles", we_count - we0, 1);
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h3FF;
        wait_ack(n);
        chk("rd_latency", n, 3);
        chk("rd_beef", cpu_rdata, 16'hBEEF);

        // Collision: video first, host next edge
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'd20;
        vid_req = 1; vid_addr = 10'd30;
        step();
        vid_req = 0;
        n = 1;
        while (!cpu_ack && n < 12) begin
            step();
            n++;
        end
        cpu_req = 0;
        chk("coll_latency", n, 4);
        chk("coll_no_miss", vid_miss, 1'b0);

        // Starvation: host forced on the 4th edge, one video request dropped
        vv0 = vv_count;
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'd50;
        for (int i = 0; i < 10; i++) begin
            vid_req = 1; vid_addr = AW'(40 + i);
            step();
            if (cpu_ack) cpu_req = 0;
        end
        vid_req = 0;
        repeat (3) begin
            step();
            if (cpu_ack) cpu_req = 0;
        end
        cpu_req = 0;
        chk("starve_vv_count", vv_count - vv0, 9);
        chk("starve_miss", vid_miss, 1'b1);

        // Reset while host is in C_ISSUED
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'd7;
        step();
        reset = 1;
        #1;
        chk("arst_ram_we",    ram_we,    1'b0);
        chk("arst_ram_addr",  ram_addr,  10'h0);
        chk("arst_vid_miss",  vid_miss,  1'b0);
        chk("arst_cpu_ack",   cpu_ack,   1'b0);
        chk("arst_vid_valid", vid_valid, 1'b0);
        cpu_req = 0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 0;
        repeat (4) step();
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h3FF;
        wait_ack(n);
        chk("post_rst_rd", cpu_rdata, 16'hBEEF);

        // Address wrap 3FF -> 000
        vid_req = 1; vid_addr = 10'h3FF; step();
        vid_req = 1; vid_addr = 10'h000; step();
        vid_req = 0;
        step();
        chk("wrap_3ff", vid_data, 16'hBEEF);
        step();
        chk("wrap_000", vid_data, 16'h0100);
        step();

        // Random mixed traffic
        for (int i = 0; i < 400; i++) begin
            vid_req  = ($urandom_range(0, 9) < 7);
            vid_addr = AW'($urandom_range(0, 15));
            if (!cpu_req && $urandom_range(0, 2) == 0) begin
                cpu_req = 1; cpu_we = $urandom_range(0, 1) == 1;
                cpu_addr = AW'($urandom_range(0, 15)); cpu_wdata = DW'($urandom);
            end
            step();
            if (cpu_ack) begin
                cpu_req = ($urandom_range(0, 1) == 1);
                cpu_we = $urandom_range(0, 1) == 1;
                cpu_addr = AW'($urandom_range(0, 15)); cpu_wdata = DW'($urandom);
            end
        end
        vid_req = 0; cpu_req = 0;
        repeat (4) step();

        $display("%0d/%0d checks passed", pass_cnt, checks);
        $finish;
    end

endmodule
